// File: rtl/program_loader.sv
// program_loader
//   Writer side of the instruction memory. Receives a program as a byte
//   stream (valid/ready), assembles little-endian 32-bit words and writes them
//   to instruction RAM at consecutive word addresses starting at BASE_ADDR.
//   The CPU is held in reset until a load completes successfully.
//
//   Stream format: 4-byte LE length N (in words), then N words, LSB first.
//
// Ports
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous active-high reset
//   start        in   1   one-cycle pulse, begins a load (honoured in IDLE/DONE/ERROR)
//   in_valid     in   1   in_byte is valid
//   in_byte      in   8   stream byte
//   in_ready     out  1   loader accepts in_byte this cycle (LEN and DATA only)
//   mem_we       out  1   imem write enable, one cycle per word
//   mem_address  out  32  imem byte address, word aligned
//   mem_data     out  32  imem write data
//   cpu_hold     out  1   holds the CPU in reset while high
//   done         out  1   load finished OK (level)
//   error        out  1   length rejected (level)
//   words_loaded out  16  words written in the current or last load
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

  state_t      state_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] len_q;
  logic [31:0] word_q;
  logic        in_ready_q;
  logic        mem_we_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_data_q;
  logic        cpu_hold_q;
  logic        done_q;
  logic        error_q;
  logic [15:0] words_loaded_q;

  logic        byte_xfer;
  logic [31:0] len_d;
  logic [31:0] word_d;
  logic [15:0] words_loaded_d;
  logic        last_word;
  logic [31:0] write_addr;

  // Byte-lane merge of the incoming byte into the length and data registers.
  always_comb begin
    byte_xfer      = in_valid && in_ready_q;
    len_d          = len_q;
    word_d         = word_q;
    len_d[{3'd0, byte_cnt_q} * 5'd8 +: 8]  = in_byte;
    word_d[{3'd0, byte_cnt_q} * 5'd8 +: 8] = in_byte;
    words_loaded_d = words_loaded_q + 16'd1;
    // N is compared as a full 32-bit value so huge lengths never alias.
    last_word      = ({16'd0, words_loaded_d} == len_q);
    write_addr     = BASE_ADDR + {14'd0, words_loaded_q, 2'b00};
  end

  // Load FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      byte_cnt_q     <= 2'd0;
      len_q          <= 32'd0;
      word_q         <= 32'd0;
      in_ready_q     <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_address_q  <= BASE_ADDR;
      mem_data_q     <= 32'd0;
      cpu_hold_q     <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= 16'd0;
    end else begin
      // Write strobe is a single-cycle pulse unless re-armed below.
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q        <= S_LEN;
            byte_cnt_q     <= 2'd0;
            in_ready_q     <= 1'b1;
            words_loaded_q <= 16'd0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            cpu_hold_q     <= 1'b1;
          end
        end
        S_LEN: begin
          if (byte_xfer) begin
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              if (len_d == 32'd0) begin
                state_q    <= S_DONE;
                in_ready_q <= 1'b0;
                done_q     <= 1'b1;
                cpu_hold_q <= 1'b0;
              end else if (len_d > MAX_WORDS_W) begin
                state_q    <= S_ERROR;
                in_ready_q <= 1'b0;
                error_q    <= 1'b1;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (byte_xfer) begin
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              // Present the write during the WRITE cycle itself.
              state_q       <= S_WRITE;
              in_ready_q    <= 1'b0;
              mem_we_q      <= 1'b1;
              mem_address_q <= write_addr;
              mem_data_q    <= word_d;
            end
          end
        end
        S_WRITE: begin
          words_loaded_q <= words_loaded_d;
          if (last_word) begin
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
          end else begin
            state_q    <= S_DATA;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_address  = mem_address_q;
  assign mem_data     = mem_data_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule
